// File: rtl/udp_arb_pkg.sv
// rtl/udp_arb_pkg.sv - shared types for the UDP TX header/payload arbiter
package udp_arb_pkg;

  typedef struct packed {
    logic [5:0]  ip_dscp;
    logic [1:0]  ip_ecn;
    logic [7:0]  ip_ttl;
    logic [31:0] ip_source_ip;
    logic [31:0] ip_dest_ip;
    logic [15:0] source_port;
    logic [15:0] dest_port;
    logic [15:0] length;
    logic [15:0] checksum;
  } udp_tx_hdr_t;

  localparam int HDR_W = $bits(udp_tx_hdr_t);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, ABORT, DROP} arb_state_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - round-robin first-set-bit search from a base pointer
module rr_priority_select #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] base_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum_w;

  // rotate so base_i lands at bit 0, search upward, then undo the rotation
  assign req2 = {req_i, req_i};
  assign rot  = req2[base_i +: N];

  always_comb begin
    found_o = 1'b0;
    off     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found_o = 1'b1;
        off     = IW'(i);
      end
    end
  end

  assign sum_w = {1'b0, base_i} + {1'b0, off};
  assign idx_o = (sum_w >= N_W) ? IW'(sum_w - N_W) : sum_w[IW-1:0];

endmodule

// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - frame-granular round-robin arbiter onto one UDP TX sink
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         s_hdr_valid,
  output logic [NUM_PORTS-1:0]         s_hdr_ready,
  input  logic [NUM_PORTS*HDR_W-1:0]   s_hdr,
  input  logic [NUM_PORTS*8-1:0]       s_tdata,
  input  logic [NUM_PORTS-1:0]         s_tvalid,
  output logic [NUM_PORTS-1:0]         s_tready,
  input  logic [NUM_PORTS-1:0]         s_tlast,
  input  logic [NUM_PORTS-1:0]         s_tuser,
  output logic                         m_hdr_valid,
  input  logic                         m_hdr_ready,
  output logic [HDR_W-1:0]             m_hdr,
  output logic [7:0]                   m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast,
  output logic                         m_tuser,
  output logic                         grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0] grant_index,
  output logic                         timeout_pulse
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int CW = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  arb_state_t    state_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] rr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tmo_q;

  logic [HDR_W-1:0] hdr_arr  [NUM_PORTS];
  logic [7:0]       data_arr [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign hdr_arr[p]  = s_hdr[p*HDR_W +: HDR_W];
    assign data_arr[p] = s_tdata[p*8 +: 8];
  end

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] next_ptr;
  logic          g_hdr_valid;
  logic          g_tvalid;
  logic          g_tlast;
  logic          stall_hit;

  rr_priority_select #(.N(NUM_PORTS)) u_sel (
    .req_i   (s_hdr_valid),
    .base_i  (rr_q),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  assign g_hdr_valid = s_hdr_valid[grant_q];
  assign g_tvalid    = s_tvalid[grant_q];
  assign g_tlast     = s_tlast[grant_q];
  assign next_ptr    = IW'(wrap_inc(int'(grant_q), NUM_PORTS));

  // only missing source data counts as a stall; sink backpressure keeps the count at zero
  assign cnt_d     = g_tvalid ? '0 : cnt_q + CW'(1);
  assign stall_hit = WD_EN && !g_tvalid && (cnt_d == TMO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_q <= sel_idx;
            state_q <= HDR;
          end
        end
        HDR: begin
          if (g_hdr_valid && m_hdr_ready) begin
            cnt_q   <= '0;
            state_q <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (g_tvalid && m_tready && g_tlast) begin
            rr_q    <= next_ptr;
            state_q <= IDLE;
          end else if (stall_hit) begin
            tmo_q   <= 1'b1;
            state_q <= ABORT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ABORT: begin
          if (m_tready) state_q <= DROP;
        end
        DROP: begin
          if (g_tvalid && g_tlast) begin
            rr_q    <= next_ptr;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_hdr_ready = '0;
    s_tready    = '0;
    m_hdr_valid = 1'b0;
    m_hdr       = hdr_arr[grant_q];
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tuser     = 1'b0;
    case (state_q)
      HDR: begin
        m_hdr_valid          = g_hdr_valid;
        s_hdr_ready[grant_q] = m_hdr_ready;
      end
      PAYLOAD: begin
        m_tdata           = data_arr[grant_q];
        m_tvalid          = g_tvalid;
        m_tlast           = g_tlast;
        m_tuser           = s_tuser[grant_q];
        s_tready[grant_q] = m_tready;
      end
      ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
      end
      DROP: begin
        s_tready[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant_valid   = (state_q != IDLE);
  assign grant_index   = grant_q;
  assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - self-checking bench for udp_tx_arbiter
`timescale 1ns/1ps
module tb_udp_tx_arbiter;
  import udp_arb_pkg::*;

  localparam int NP   = 3;
  localparam int TMO  = 8;
  localparam int HW   = $bits(udp_tx_hdr_t);
  localparam int MAXF = 64;

  logic clk = 1'b0;
  logic reset;
  logic [NP-1:0]    s_hdr_valid, s_hdr_ready, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [NP*HW-1:0] s_hdr;
  logic [NP*8-1:0]  s_tdata;
  logic             m_hdr_valid, m_hdr_ready, m_tvalid, m_tready, m_tlast, m_tuser;
  logic [HW-1:0]    m_hdr;
  logic [7:0]       m_tdata;
  logic             grant_valid, timeout_pulse;
  logic [$clog2(NP)-1:0] grant_index;

  udp_tx_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready), .s_hdr(s_hdr),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready), .m_hdr(m_hdr),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .grant_valid(grant_valid), .grant_index(grant_index), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          scen;
    int          port;
    int          len;
    int          stall_at;
    int          stall_len;
    logic [15:0] dport;
    logic [31:0] seed;
    int          tmode;
    bit          exp_abort;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  int            f_port [MAXF];
  int            f_len  [MAXF];
  int            f_sat  [MAXF];
  int            f_slen [MAXF];
  bit            f_abort[MAXF];
  logic [HW-1:0] f_hdr  [MAXF];
  logic [7:0]    f_data [MAXF][64];
  int            pq[NP][$];
  int            exp_order[$];
  int            m_rr;
  int            d_cur[NP], d_phase[NP], d_idx[NP], d_gap[NP];

  task automatic check_i(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_h(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void add(int sc, int p, int l, int sa, int sl, logic [15:0] dp,
                              logic [31:0] sd, int tm, bit ea);
    vec_t v;
    v.scen = sc; v.port = p; v.len = l; v.stall_at = sa; v.stall_len = sl;
    v.dport = dp; v.seed = sd; v.tmode = tm; v.exp_abort = ea;
    vecs.push_back(v);
  endfunction

  function automatic int rgap(int tm);
    return (tm == 2) ? int'($urandom_range(0, 3)) : 0;
  endfunction

  task automatic next_frame(input int p, input int tm);
    if (pq[p].size() > 0) begin
      d_cur[p]   = pq[p].pop_front();
      d_phase[p] = 1;
    end else begin
      d_phase[p] = 0;
    end
    d_idx[p] = 0;
    d_gap[p] = rgap(tm);
  endtask

  task automatic run_scen(input int s);
    int mq[NP][$];
    int tmode, nf, cyc, ocnt, bcnt, nexp, idle, pulses, exp_pulses, cur_f;
    bit done, in_frame, seen_hv;
    logic [7:0] ed;
    logic el, eu;
    logic [31:0] sd;
    udp_tx_hdr_t h;
    nf = 0; tmode = 0; exp_pulses = 0;
    exp_order.delete();
    for (int p = 0; p < NP; p++) pq[p].delete();
    foreach (vecs[i]) begin
      if (vecs[i].scen == s) begin
        f_port[nf] = vecs[i].port; f_len[nf] = vecs[i].len;
        f_sat[nf] = vecs[i].stall_at; f_slen[nf] = vecs[i].stall_len;
        f_abort[nf] = vecs[i].exp_abort;
        h.ip_dscp = 6'($urandom); h.ip_ecn = 2'($urandom); h.ip_ttl = 8'($urandom);
        h.ip_source_ip = $urandom; h.ip_dest_ip = $urandom;
        h.source_port = 16'(nf); h.dest_port = vecs[i].dport;
        h.length = 16'(vecs[i].len + 8); h.checksum = 16'($urandom);
        f_hdr[nf] = h;
        sd = vecs[i].seed;
        for (int j = 0; j < vecs[i].len; j++)
          f_data[nf][j] = (j < 4) ? sd[31-8*j -: 8] : 8'(sd[7:0] + 8'(j * 37));
        pq[vecs[i].port].push_back(nf);
        tmode = vecs[i].tmode;
        if (vecs[i].exp_abort) exp_pulses++;
        nf++;
      end
    end
    // every header is offered at once, so service order is plain round-robin over non-empty queues
    for (int p = 0; p < NP; p++) mq[p] = pq[p];
    for (int k = 0; k < nf; k++) begin
      for (int i = 0; i < NP; i++) begin
        int p;
        p = (m_rr + i) % NP;
        if (mq[p].size() > 0) begin
          exp_order.push_back(mq[p].pop_front());
          m_rr = (p + 1) % NP;
          break;
        end
      end
    end
    for (int p = 0; p < NP; p++) next_frame(p, tmode);
    ocnt = 0; bcnt = 0; nexp = 0; idle = 0; pulses = 0; cur_f = 0;
    done = 1'b0; in_frame = 1'b0; seen_hv = 1'b0;
    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        s_hdr_valid[p]        = (d_phase[p] == 1);
        s_hdr[p*HW +: HW]     = f_hdr[d_cur[p]];
        s_tvalid[p]           = (d_phase[p] == 2) && (d_gap[p] == 0);
        s_tdata[p*8 +: 8]     = f_data[d_cur[p]][d_idx[p]];
        s_tlast[p]            = (d_idx[p] == f_len[d_cur[p]] - 1);
        s_tuser[p]            = f_data[d_cur[p]][d_idx[p]][7];
      end
      m_tready    = (tmode == 0) ? 1'b1 : (tmode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 3) != 0);
      m_hdr_ready = (tmode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (timeout_pulse) pulses++;
      if (!grant_valid) idle++;
      if (m_hdr_valid && !seen_hv) begin
        seen_hv = 1'b1;
        check_i("hdr_latency", cyc, 1);
      end
      if (m_hdr_valid && m_hdr_ready) begin
        if (ocnt >= exp_order.size() || in_frame) begin
          check_i("unexpected_hdr", 1, 0);
        end else begin
          cur_f = exp_order[ocnt];
          if (ocnt > 0) check_i("idle_gap", idle, 1);
          check_h("hdr", m_hdr, f_hdr[cur_f]);
          check_i("grant", int'(grant_index), f_port[cur_f]);
          bcnt = 0; in_frame = 1'b1;
          nexp = f_abort[cur_f] ? f_sat[cur_f] + 1 : f_len[cur_f];
        end
        idle = 0;
      end
      if (m_tvalid && m_tready) begin
        if (!in_frame) begin
          check_i("unexpected_beat", 1, 0);
        end else begin
          if (f_abort[cur_f] && bcnt == f_sat[cur_f]) begin
            ed = 8'h00; el = 1'b1; eu = 1'b1;
          end else begin
            ed = f_data[cur_f][bcnt]; el = (bcnt == f_len[cur_f] - 1); eu = ed[7];
          end
          check_i("beat", int'({m_tdata, m_tlast, m_tuser}), int'({ed, el, eu}));
          bcnt++;
          if (bcnt == nexp) begin
            in_frame = 1'b0;
            ocnt++;
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (d_phase[p] == 1 && s_hdr_ready[p]) begin
          d_phase[p] = 2; d_idx[p] = 0;
          d_gap[p] = (f_sat[d_cur[p]] == 0) ? f_slen[d_cur[p]] : rgap(tmode);
        end else if (d_phase[p] == 2) begin
          if (d_gap[p] > 0) d_gap[p]--;
          else if (s_tready[p]) begin
            if (d_idx[p] == f_len[d_cur[p]] - 1) next_frame(p, tmode);
            else begin
              d_idx[p]++;
              d_gap[p] = (d_idx[p] == f_sat[d_cur[p]]) ? f_slen[d_cur[p]] : rgap(tmode);
            end
          end
        end
      end
      done = (ocnt == exp_order.size()) && !in_frame;
      for (int p = 0; p < NP; p++) if (d_phase[p] != 0) done = 1'b0;
    end
    check_i("scen_done", int'(done), 1);
    check_i("timeout_pulses", pulses, exp_pulses);
    @(negedge clk);
    s_hdr_valid = '0; s_tvalid = '0;
    #1;
    check_i("back_to_idle", int'(grant_valid), 0);
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // scen, port, len, stall_at, stall_len, dest_port, seed, tready mode, expected abort
    add(1, 0, 4,  -1, 0, 16'd1234, 32'hDEADBEEF, 0, 1'b0);
    add(2, 0, 3,  -1, 0, 16'd10,   32'h01020304, 0, 1'b0);
    add(2, 1, 3,  -1, 0, 16'd11,   32'h11121314, 0, 1'b0);
    add(2, 0, 3,  -1, 0, 16'd12,   32'h21222324, 0, 1'b0);
    add(2, 1, 3,  -1, 0, 16'd13,   32'h31323334, 0, 1'b0);
    add(3, 0, 64, -1, 0, 16'd20,   32'hA0B0C0D0, 1, 1'b0);
    add(4, 1, 5,  2,  8, 16'd30,   32'h55667788, 0, 1'b1);
    add(4, 0, 3,  -1, 0, 16'd31,   32'h99AABBCC, 0, 1'b0);
    add(5, 2, 4,  2,  7, 16'd40,   32'h12345678, 0, 1'b0);
    add(5, 0, 2,  0,  8, 16'd41,   32'h87654321, 0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      int p, l, sa, sl;
      p = $urandom_range(0, NP - 1);
      l = $urandom_range(1, 12);
      sa = -1; sl = 0;
      if ($urandom_range(0, 4) == 0) begin
        sa = $urandom_range(0, l - 1);
        case ($urandom_range(0, 2))
          0: sl = 7;
          1: sl = 8;
          default: sl = 11;
        endcase
      end
      add(6, p, l, sa, sl, 16'($urandom), $urandom, 2, (sa >= 0) && (sl >= TMO));
    end
    add(7, 1, 2, -1, 0, 16'd70, 32'hCAFEF00D, 0, 1'b0);

    reset = 1'b0;
    s_hdr_valid = '1; s_hdr = '0; s_tdata = '0; s_tvalid = '1; s_tlast = '0; s_tuser = '0;
    m_hdr_ready = 1'b1; m_tready = 1'b1;
    m_rr = 0;
    repeat (2) @(negedge clk);
    #1;
    check_i("rst_grant_valid", int'(grant_valid), 0);
    check_i("rst_grant_index", int'(grant_index), 0);
    check_i("rst_valids", int'({m_hdr_valid, m_tvalid, timeout_pulse}), 0);
    check_i("rst_readies", int'({s_hdr_ready, s_tready}), 0);
    @(negedge clk);
    s_hdr_valid = '0; s_tvalid = '0;
    reset = 1'b1;
    @(negedge clk);

    for (int s = 1; s <= 7; s++) run_scen(s);

    // asynchronous reset in the middle of a payload from requester 2
    s_hdr_valid = 3'b100; s_hdr[2*HW +: HW] = f_hdr[0];
    m_hdr_ready = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (s_hdr_ready[2]) break;
    end
    check_i("mid_hdr_ready", int'(s_hdr_ready[2]), 1);
    check_i("mid_grant", int'(grant_index), 2);
    @(negedge clk);
    s_hdr_valid = '0; s_tvalid = 3'b100; s_tdata[23:16] = 8'h55; s_tlast = '0;
    #1;
    check_i("mid_tvalid", int'(m_tvalid), 1);
    #1;
    reset = 1'b0;
    #1;
    check_i("async_rst_valids", int'({m_hdr_valid, m_tvalid, grant_valid}), 0);
    check_i("async_rst_readies", int'({s_hdr_ready, s_tready}), 0);
    check_i("async_rst_grant", int'(grant_index), 0);
    @(negedge clk);
    s_tvalid = '0; s_hdr_valid = 3'b111;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_i("post_rst_grant_valid", int'(grant_valid), 1);
    check_i("post_rst_grant_index", int'(grant_index), 0);
    s_hdr_valid = '0;
    reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
